// File: rtl/write_back_unit_pkg.sv
// Shared processor constants: register-file geometry, the hard-wired zero register
// and the load-result entry layout used by the write-back stage.
package write_back_unit_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'b11111;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    localparam int ENTRY_W = REG_ADDR_W + DATA_W;
endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding load results until the register-file write port is free.
module wb_fifo
    import write_back_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENTRY_W,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still accepts an entry when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: arbitrates ALU results (priority) against buffered load results
// onto a registered register-file write port, and tracks outstanding loads per register.
module write_back_unit
    import write_back_unit_pkg::*;
#(
    parameter logic [4:0] ZERO_REG   = write_back_unit_pkg::ZERO_REG,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic        write_enable,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic [31:0] pending,
    output logic [1:0]  fifo_count
);
    logic            alu_hit;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic            load_write;
    logic [ENTRY_W-1:0] fifo_dout;
    wb_entry_t       head;
    logic            nxt_we;
    logic [4:0]      nxt_addr;
    logic [31:0]     nxt_data;
    logic [31:0]     set_vec;
    logic [31:0]     clr_vec;

    assign mem_ready = (int'(fifo_count) < FIFO_DEPTH);
    assign alu_hit   = alu_valid && (alu_addr != ZERO_REG);
    assign fifo_pop  = !alu_hit && !fifo_empty;
    assign head      = wb_entry_t'(fifo_dout);
    // A popped zero-register load is dropped silently: no write, no scoreboard change.
    assign load_write = fifo_pop && (head.addr != ZERO_REG);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W),
        .CW    (2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mem_valid && mem_ready),
        .din   ({mem_addr, mem_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        nxt_we   = 1'b0;
        nxt_addr = '0;
        nxt_data = '0;
        if (alu_hit) begin
            nxt_we   = 1'b1;
            nxt_addr = alu_addr;
            nxt_data = alu_data;
        end else if (load_write) begin
            nxt_we   = 1'b1;
            nxt_addr = head.addr;
            nxt_data = head.data;
        end
    end

    assign set_vec = (issue_valid && issue_addr != ZERO_REG) ? (32'd1 << issue_addr) : '0;
    assign clr_vec = load_write ? (32'd1 << head.addr) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            pending      <= '0;
        end else begin
            write_enable <= nxt_we;
            write_addr   <= nxt_addr;
            write_data   <= nxt_data;
            // Set is applied after clear so a same-cycle re-issue keeps the bit.
            pending      <= ((pending & ~clr_vec) | set_vec) & ~(32'd1 << ZERO_REG);
        end
    end
endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit with a queue-based reference model checked every cycle.
module tb_write_back_unit;
    localparam int          DEPTH = 2;
    localparam logic [4:0]  ZR    = 5'd31;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pending;
    logic [1:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    write_back_unit #(.ZERO_REG(ZR), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .pending      (pending),
        .fifo_count   (fifo_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: load buffer as a queue, scoreboard as a bit array
    logic [36:0] exp_q[$];
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic [31:0] exp_pend;
    bit          model_live = 1'b0;

    always @(posedge clk) begin
        logic [36:0] e;
        bit room;
        if (rst) begin
            exp_q.delete();
            exp_we = 1'b0; exp_wa = '0; exp_wd = '0; exp_pend = '0;
            model_live = 1'b1;
        end else begin
            room = (exp_q.size() < DEPTH);
            exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
            if (alu_valid && alu_addr != ZR) begin
                exp_we = 1'b1; exp_wa = alu_addr; exp_wd = alu_data;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e[36:32] != ZR) begin
                    exp_we = 1'b1; exp_wa = e[36:32]; exp_wd = e[31:0];
                    exp_pend[e[36:32]] = 1'b0;
                end
            end
            if (mem_valid && room) exp_q.push_back({mem_addr, mem_data});
            if (issue_valid && issue_addr != ZR) exp_pend[issue_addr] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (model_live) begin
            check("model_we",    32'(write_enable), 32'(exp_we));
            check("model_waddr", 32'(write_addr),   32'(exp_wa));
            check("model_wdata", write_data,        exp_wd);
            check("model_pend",  pending,           exp_pend);
            check("model_count", 32'(fifo_count),   32'(exp_q.size()));
            check("model_ready", 32'(mem_ready),    32'(exp_q.size() < DEPTH));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        issue_valid = 0; issue_addr = 0;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        alu_valid = v; alu_addr = a; alu_data = d;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
        mem_valid = v; mem_addr = a; mem_data = d;
    endtask

    task automatic drive_issue(input logic v, input logic [4:0] a);
        issue_valid = v; issue_addr = a;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        // reset then idle
        check("idle_we",    32'(write_enable), 32'd0);
        check("idle_pend",  pending,           32'd0);
        check("idle_ready", 32'(mem_ready),    32'd1);
        check("idle_count", 32'(fifo_count),   32'd0);

        // single ALU write, visible for exactly one cycle
        drive_alu(1, 5'd5, 32'hDEADBEEF);
        tick();
        drive_alu(0, 0, 0);
        check("alu_we",    32'(write_enable), 32'd1);
        check("alu_waddr", 32'(write_addr),   32'd5);
        check("alu_wdata", write_data,        32'hDEADBEEF);
        tick();
        check("alu_we_off",    32'(write_enable), 32'd0);
        check("alu_waddr_off", 32'(write_addr),   32'd0);

        // load to r7 collides with ALU r3
        drive_issue(1, 5'd7);
        tick();
        drive_issue(0, 0);
        check("issue_r7", pending, 32'h0000_0080);
        drive_mem(1, 5'd7, 32'h12);
        drive_alu(1, 5'd3, 32'h34);
        tick();
        idle_inputs();
        check("coll_alu_addr", 32'(write_addr), 32'd3);
        check("coll_alu_data", write_data,      32'h34);
        check("coll_pend_held", pending,        32'h0000_0080);
        tick();
        check("coll_ld_addr", 32'(write_addr), 32'd7);
        check("coll_ld_data", write_data,      32'h12);
        check("coll_pend_clr", pending,        32'd0);

        // three pushes under continuous ALU traffic
        drive_alu(1, 5'd1, 32'h100);
        drive_mem(1, 5'd10, 32'hA);
        tick();
        drive_alu(1, 5'd1, 32'h101);
        drive_mem(1, 5'd11, 32'hB);
        tick();
        check("full_count", 32'(fifo_count), 32'd2);
        check("full_ready", 32'(mem_ready),  32'd0);
        drive_alu(1, 5'd1, 32'h102);
        drive_mem(1, 5'd12, 32'hC);
        tick();
        check("refuse_count", 32'(fifo_count), 32'd2);
        check("refuse_wdata", write_data,      32'h102);
        idle_inputs();
        tick();
        check("drain0_addr", 32'(write_addr), 32'd10);
        check("drain0_data", write_data,      32'hA);
        tick();
        check("drain1_addr", 32'(write_addr), 32'd11);
        check("drain1_cnt",  32'(fifo_count), 32'd0);
        tick();
        check("drain_done", 32'(write_enable), 32'd0);

        // re-issue of r9 on the same edge its load is written back
        drive_mem(1, 5'd9, 32'h99);
        tick();
        drive_mem(0, 0, 0);
        drive_issue(1, 5'd9);
        tick();
        drive_issue(0, 0);
        check("reissue_addr", 32'(write_addr), 32'd9);
        check("reissue_pend", pending,         32'h0000_0200);
        // zero-register load is dropped
        drive_mem(1, ZR, 32'h55);
        tick();
        drive_mem(0, 0, 0);
        tick();
        check("zr_we",   32'(write_enable), 32'd0);
        check("zr_pend", pending,           32'h0000_0200);
        check("zr_cnt",  32'(fifo_count),   32'd0);

        // ALU write to r31 does not block a pop
        drive_mem(1, 5'd4, 32'h44);
        tick();
        drive_mem(0, 0, 0);
        drive_alu(1, ZR, 32'hFFFF);
        tick();
        drive_alu(0, 0, 0);
        check("alu_zr_pop", 32'(write_addr), 32'd4);
        check("alu_zr_data", write_data,     32'h44);

        // streaming pushes and pops across pointer wrap
        for (int i = 0; i < 6; i++) begin
            drive_mem(1, 5'(12 + i), 32'h1000 + 32'(i));
            drive_issue(1, 5'(12 + i));
            tick();
        end
        idle_inputs();
        tick(); tick();

        // mid-operation reset with a full buffer
        drive_issue(1, 5'd20);
        drive_alu(1, 5'd2, 32'h2);
        drive_mem(1, 5'd21, 32'h21);
        tick();
        drive_mem(1, 5'd22, 32'h22);
        tick();
        check("prerst_count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        drive_issue(1, 5'd6);
        tick();
        check("rst_we",    32'(write_enable), 32'd0);
        check("rst_count", 32'(fifo_count),   32'd0);
        check("rst_pend",  pending,           32'd0);
        idle_inputs();
        rst = 1'b0;
        check("rst_ready", 32'(mem_ready), 32'd1);
        tick();
        check("post_rst_we", 32'(write_enable), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 SHALL have parameter ZERO_REG, default 5'b11111, the hard-wired zero register index whose writes are discarded.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the number of load-result buffer entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports alu_valid/alu_addr/alu_data, input, 1/5/32, the single-cycle ALU result, which has no backpressure.
REQ-006 SHALL have ports mem_valid/mem_addr/mem_data, input, 1/5/32, the load-unit result.
REQ-007 SHALL have port mem_ready, output, 1, high when the load FIFO can accept an entry.
REQ-008 SHALL have ports issue_valid/issue_addr, input, 1/5, which mark a load destination as pending at issue.
REQ-009 SHALL have ports write_enable/write_addr/write_data, output, 1/5/32, the register file write port; all three are registered.
REQ-010 SHALL have port pending, output, 32, the per-register outstanding-load scoreboard for the decode stall logic.
REQ-011 SHALL have port fifo_count, output, 2, the current load FIFO occupancy.

Function
REQ-012 SHALL accept a load result on a cycle where mem_valid && mem_ready, and push {addr,data} into the FIFO.
REQ-013 SHALL drive mem_ready = (fifo_count < FIFO_DEPTH), purely from registered state.
REQ-014 SHALL give the ALU absolute priority: when alu_valid && alu_addr != ZERO_REG, the next write port value is the ALU result.
REQ-015 SHALL pop the FIFO head to the write port when no qualifying ALU write is present and the FIFO is non-empty.
REQ-016 SHALL pop and discard a FIFO head whose addr == ZERO_REG, leaving write_enable low for that slot, and clear nothing in pending.
REQ-017 SHALL give every write a latency of exactly 1 cycle: a source sampled at edge N appears on the write port during cycle N+1.
REQ-018 SHALL ignore alu_valid with alu_addr == ZERO_REG, which then does not block the FIFO pop in the same cycle.
REQ-019 SHALL handle a simultaneous push and pop by keeping fifo_count unchanged, and SHALL allow a push when full only if a pop occurs that cycle. mem_ready stays registered and conservative.
REQ-020 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH, preserving FIFO order across the wrap.
REQ-021 SHALL set pending[issue_addr] on issue_valid when issue_addr != ZERO_REG.
REQ-022 SHALL clear pending[a] on the edge where a FIFO entry with addr a is written.
REQ-023 SHALL let set win over clear when a set and a clear target the same bit in the same cycle.
REQ-024 SHALL keep pending[ZERO_REG] at 0 at all times.
REQ-025 SHALL NOT alter pending on an ALU write to a pending register; ordering is the issue logic's responsibility.
REQ-026 SHALL drive write_addr/write_data to 0 whenever write_enable is 0.

Reset
REQ-027 SHALL, while rst is high at an edge, drive write_enable=0, write_addr=0, write_data=0, pending=0, fifo_count=0 and set the pointers to 0.
REQ-028 SHALL discard buffered load results on a mid-operation reset, leaving no write issued in the cycle after reset.
REQ-029 SHALL force mem_ready high in the first cycle after reset is released.
REQ-030 SHALL ignore all inputs during reset.

Structure
REQ-031 SHALL place ZERO_REG, the register-address width (5) and the data width (32) in the shared processor package, alongside the register file constants.
REQ-032 SHALL implement the load buffer as one sub-module, wb_fifo (push/pop/full/empty/count), instantiated once.
REQ-033 SHALL keep the arbitration, write-port registers and scoreboard in the top module.

Verification
REQ-034 Reset then idle -> write_enable=0, pending=0, mem_ready=1, fifo_count=0.
REQ-035 alu_valid, addr=5, data=0xDEADBEEF at edge N -> write_enable=1, write_addr=5, write_data=0xDEADBEEF during N+1 only.
REQ-036 Issue load to r7, then mem result r7=0x12 in the same cycle as ALU r3=0x34 -> r3 written at N+1, r7 written at N+2, pending[7] cleared at N+2.
REQ-037 Three mem pushes under continuous ALU writes -> third push refused (mem_ready=0, fifo_count=2), then both entries drained in order once the ALU goes idle.
REQ-038 issue_valid addr=9 coinciding with a FIFO write to r9 -> pending[9] remains 1; a mem result to r31 -> no write, pending unchanged.
REQ-039 rst asserted with fifo_count=2 -> next cycle write_enable=0, fifo_count=0, pending=0.
